// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the PLL-qualified reset sequencer.
// RST_SEQ_LOSS_CNT_EN, when defined, enables the lock-loss event counter.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int LOSS_CNT_W = 8;

  // Timer wide enough to hold the larger of the two windows.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Lock input and staged reset outputs of rst_sequencer.
// loss_cnt exists only when RST_SEQ_LOSS_CNT_EN is defined.
interface rst_seq_if
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES = 3
) ();

  logic                  pll_locked;
  logic [N_STAGES-1:0]   rst_out;
  logic                  ready;
`ifdef RST_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt;

  modport master (input pll_locked, output rst_out, output ready, output loss_cnt);
  modport slave  (output pll_locked, input rst_out, input ready, input loss_cnt);
`else
  modport master (input pll_locked, output rst_out, output ready);
  modport slave  (output pll_locked, input rst_out, input ready);
`endif

endinterface

// File: rtl/rst_seq_sat_cnt.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module rst_seq_sat_cnt
  import rst_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  inc,
  output logic [LOSS_CNT_W-1:0] cnt
);

  logic [LOSS_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + LOSS_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rst_sequencer.sv
// Qualifies PLL lock for a settle window, then releases staged resets in order.
// Define RST_SEQ_LOSS_CNT_EN to add the saturating lock-loss counter.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYC = 4800,
  parameter int STAGE_GAP_CYC   = 480,
  parameter int N_STAGES        = 3
) (
  input  logic   clock_in,
  input  logic   rst_in,
  rst_seq_if.master bus
);

  localparam int CNT_W = cnt_width(LOCK_STABLE_CYC, STAGE_GAP_CYC);
  localparam int STG_W = $clog2(N_STAGES + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STG_W-1:0]    stage_q, stage_d;
  logic [N_STAGES-1:0] rst_out_q, rst_out_d;
  logic                ready_q, ready_d;
  logic                loss_ev;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    loss_ev   = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        if (bus.pll_locked) begin
          state_d = STABILIZE;
          cnt_d   = CNT_W'(1);
        end
      end
      STABILIZE: begin
        if (cnt_q == CNT_W'(LOCK_STABLE_CYC)) begin
          rst_out_d[0] = 1'b0;
          cnt_d        = '0;
          if (N_STAGES == 1) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            state_d = RELEASE;
            stage_d = STG_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == CNT_W'(STAGE_GAP_CYC - 1)) begin
          for (int i = 0; i < N_STAGES; i++)
            if (STG_W'(i) == stage_q) rst_out_d[i] = 1'b0;
          cnt_d   = '0;
          stage_d = stage_q + STG_W'(1);
          if (stage_q == STG_W'(N_STAGES - 1)) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: ;
      default: state_d = WAIT_LOCK;
    endcase

    // Lock loss anywhere past WAIT_LOCK aborts the whole sequence at once.
    if ((state_q != WAIT_LOCK) && !bus.pll_locked) begin
      state_d   = WAIT_LOCK;
      cnt_d     = '0;
      stage_d   = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
      loss_ev   = 1'b1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      stage_q   <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.rst_out = rst_out_q;
  assign bus.ready   = ready_q;

`ifdef RST_SEQ_LOSS_CNT_EN
  rst_seq_sat_cnt u_loss_cnt (
    .clk (clock_in),
    .clr (rst_in),
    .inc (loss_ev),
    .cnt (bus.loss_cnt)
  );
`else
  logic unused_loss_ev;
  assign unused_loss_ev = loss_ev;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: 3-stage and 1-stage instances, L=8, G=4.
// Loss-counter checks are compiled in when RST_SEQ_LOSS_CNT_EN is defined.
module tb_rst_sequencer;
  import rst_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  int   n_chk = 0;
  int   n_err = 0;

  rst_seq_if #(.N_STAGES(3)) if0 ();
  rst_seq_if #(.N_STAGES(1)) if1 ();

  rst_sequencer #(.LOCK_STABLE_CYC(8), .STAGE_GAP_CYC(4), .N_STAGES(3)) u_dut3 (
    .clock_in (clk),
    .rst_in   (rst0),
    .bus      (if0.master)
  );

  rst_sequencer #(.LOCK_STABLE_CYC(8), .STAGE_GAP_CYC(4), .N_STAGES(1)) u_dut1 (
    .clock_in (clk),
    .rst_in   (rst1),
    .bus      (if1.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n edges; sample 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just before edge 0 (first edge sampling lock with rst_in low).
  task automatic chk_seq(input string tag);
    step(8);  chk({tag, " e7 rst"}, 32'(if0.rst_out), 32'b111);
              chk({tag, " e7 rdy"}, 32'(if0.ready), 32'd0);
    step(1);  chk({tag, " e8 rst"}, 32'(if0.rst_out), 32'b110);
    step(3);  chk({tag, " e11 rst"}, 32'(if0.rst_out), 32'b110);
    step(1);  chk({tag, " e12 rst"}, 32'(if0.rst_out), 32'b100);
    step(3);  chk({tag, " e15 rst"}, 32'(if0.rst_out), 32'b100);
              chk({tag, " e15 rdy"}, 32'(if0.ready), 32'd0);
    step(1);  chk({tag, " e16 rst"}, 32'(if0.rst_out), 32'b000);
              chk({tag, " e16 rdy"}, 32'(if0.ready), 32'd1);
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    if0.pll_locked = 1'b0;
    if1.pll_locked = 1'b0;
    step(3);
    chk("reset rst", 32'(if0.rst_out), 32'b111);
    chk("reset rdy", 32'(if0.ready), 32'd0);
`ifdef RST_SEQ_LOSS_CNT_EN
    chk("reset loss", 32'(if0.loss_cnt), 32'd0);
`endif
    // Lock high while rst_in still held must not start the sequence.
    if0.pll_locked = 1'b1;
    step(10);
    chk("rst hold rst", 32'(if0.rst_out), 32'b111);

    // Test 1: clean sequence.
    rst0 = 1'b0;
    chk_seq("t1");

    // Test 3: lock drop in RUN, then relock repeats the timing.
    if0.pll_locked = 1'b0;
    step(1);
    chk("t3 drop rst", 32'(if0.rst_out), 32'b111);
    chk("t3 drop rdy", 32'(if0.ready), 32'd0);
`ifdef RST_SEQ_LOSS_CNT_EN
    chk("t3 loss", 32'(if0.loss_cnt), 32'd1);
`endif
    if0.pll_locked = 1'b1;
    chk_seq("t3");

    // Test 2: one-cycle glitch at edge 5 of STABILIZE.
    if0.pll_locked = 1'b0;
    step(1);
    if0.pll_locked = 1'b1;
    step(5);
    if0.pll_locked = 1'b0;
    step(1);
    chk("t2 e5 rst", 32'(if0.rst_out), 32'b111);
    if0.pll_locked = 1'b1;
    step(8);
    chk("t2 e13 rst", 32'(if0.rst_out), 32'b111);
    step(1);
    chk("t2 e14 rst", 32'(if0.rst_out), 32'b110);
`ifdef RST_SEQ_LOSS_CNT_EN
    chk("t2 loss", 32'(if0.loss_cnt), 32'd3);
`endif

    // Test 4: rst_in at edge 13 while rst_out=100.
    rst0 = 1'b1;
    step(1);
    rst0 = 1'b0;
    step(13);
    chk("t4 e12 rst", 32'(if0.rst_out), 32'b100);
    rst0 = 1'b1;
    step(1);
    chk("t4 e13 rst", 32'(if0.rst_out), 32'b111);
    chk("t4 e13 rdy", 32'(if0.ready), 32'd0);
`ifdef RST_SEQ_LOSS_CNT_EN
    chk("t4 loss clr", 32'(if0.loss_cnt), 32'd0);
`endif
    rst0 = 1'b0;
    chk_seq("t4");

    // Test 5: single stage, rst_out and ready change together.
    rst1 = 1'b0;
    if1.pll_locked = 1'b1;
    step(8);
    chk("t5 e7 rst", 32'(if1.rst_out), 32'd1);
    chk("t5 e7 rdy", 32'(if1.ready), 32'd0);
    step(1);
    chk("t5 e8 rst", 32'(if1.rst_out), 32'd0);
    chk("t5 e8 rdy", 32'(if1.ready), 32'd1);

`ifdef RST_SEQ_LOSS_CNT_EN
    // Test 6: 300 loss events saturate at 255; rst_in clears.
    rst0 = 1'b1;
    step(1);
    rst0 = 1'b0;
    if0.pll_locked = 1'b0;
    step(1);
    chk("t6 idle loss", 32'(if0.loss_cnt), 32'd0);
    for (int i = 0; i < 300; i++) begin
      if0.pll_locked = 1'b1;
      step(1);
      if0.pll_locked = 1'b0;
      step(1);
      if (i == 2) chk("t6 loss 3", 32'(if0.loss_cnt), 32'd3);
    end
    chk("t6 sat", 32'(if0.loss_cnt), 32'd255);
    step(5);
    chk("t6 hold", 32'(if0.loss_cnt), 32'd255);
    rst0 = 1'b1;
    step(1);
    chk("t6 clr", 32'(if0.loss_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
